// File: rtl/mem_pkg.sv
// ============================================================================
// Module   : mem_pkg
// Brief    : Shared types, default widths and parity helper for param_sdp_mem.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 8;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    // Source of rd_data for the most recently accepted read
    typedef enum logic [1:0] {
        RD_ARRAY  = 2'd0,
        RD_BYPASS = 2'd1,
        RD_CLEAR  = 2'd2
    } rd_sel_t;

    function automatic logic even_parity(input logic [63:0] d);
        return ^d;
    endfunction

endpackage

`default_nettype wire

// File: rtl/param_sdp_mem_if.sv
// ============================================================================
// Module   : param_sdp_mem_if
// Brief    : Write/read request bus of param_sdp_mem with master/slave views.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface param_sdp_mem_if
    import mem_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
);
    logic              init_busy;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              parity_err;

    modport master (
        input  init_busy, rd_data, rd_valid, parity_err,
        output wr_en, wr_addr, wr_data, rd_en, rd_addr
    );

    modport slave (
        output init_busy, rd_data, rd_valid, parity_err,
        input  wr_en, wr_addr, wr_data, rd_en, rd_addr
    );
endinterface

`default_nettype wire

// File: rtl/sdp_mem_array.sv
// ============================================================================
// Module   : sdp_mem_array
// Brief    : Bare storage, one write port and one registered read port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sdp_mem_array #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  wire logic              clk,
    input  wire logic              i_we,
    input  wire logic [ADDR_W-1:0] i_waddr,
    input  wire logic [WIDTH-1:0]  i_wdata,
    input  wire logic              i_re,
    input  wire logic [ADDR_W-1:0] i_raddr,
    output logic      [WIDTH-1:0]  o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_q;

    // No reset on the array or its output register so it maps onto block RAM
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_q <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_q;

endmodule

`default_nettype wire

// File: rtl/param_sdp_mem.sv
// ============================================================================
// Module   : param_sdp_mem
// Brief    : Parametrised simple-dual-port RAM with post-reset clear sequence,
//            write-first bypass and range checks. Optional parity storage is
//            enabled by defining PARAM_SDP_MEM_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module param_sdp_mem
    import mem_pkg::*;
#(
    parameter int               DATA_W    = DEF_DATA_W,
    parameter int               ADDR_W    = DEF_ADDR_W,
    parameter int               DEPTH     = 2**ADDR_W,
    parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
    input  wire logic         clk,
    input  wire logic         rst,
    param_sdp_mem_if.slave    bus
);

`ifdef PARAM_SDP_MEM_PARITY_EN
    localparam int MEM_W = DATA_W + 1;
`else
    localparam int MEM_W = DATA_W;
`endif

    localparam logic [ADDR_W-1:0] c_LAST = ADDR_W'(DEPTH - 1);

    state_t            r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_ptr, w_ptr_nxt;
    rd_sel_t           r_sel;
    logic [DATA_W-1:0] r_byp_data;
    logic              r_rd_valid;

    logic              w_ready, w_wr_ok, w_rd_acc, w_rd_in, w_byp;
    logic              w_we, w_re;
    logic [ADDR_W-1:0] w_waddr;
    logic [DATA_W-1:0] w_wdata_raw;
    logic [MEM_W-1:0]  w_wdata, w_q;

    function automatic logic f_in_range(input logic [ADDR_W-1:0] a);
        return int'(a) < DEPTH;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_CLEAR;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            ST_CLEAR: begin
                w_ptr_nxt = r_ptr + ADDR_W'(1);
                if (r_ptr == c_LAST) begin
                    w_state_nxt = ST_READY;
                    w_ptr_nxt   = '0;
                end
            end
            default: ;
        endcase
    end

    assign w_ready  = (r_state == ST_READY);
    assign w_wr_ok  = w_ready & bus.wr_en & f_in_range(bus.wr_addr);
    assign w_rd_acc = w_ready & bus.rd_en;
    assign w_rd_in  = f_in_range(bus.rd_addr);
    assign w_byp    = w_wr_ok & w_rd_in & (bus.wr_addr == bus.rd_addr);

    // The clear sequence owns the write port until the FSM reaches READY
    assign w_we        = ~rst & (w_ready ? w_wr_ok : 1'b1);
    assign w_waddr     = w_ready ? bus.wr_addr : r_ptr;
    assign w_wdata_raw = w_ready ? bus.wr_data : CLEAR_VAL;
    assign w_re        = ~rst & w_rd_acc & w_rd_in & ~w_byp;

`ifdef PARAM_SDP_MEM_PARITY_EN
    assign w_wdata = {even_parity(64'(w_wdata_raw)), w_wdata_raw};
`else
    assign w_wdata = w_wdata_raw;
`endif

    sdp_mem_array #(
        .WIDTH  (MEM_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_re    (w_re),
        .i_raddr (bus.rd_addr),
        .o_rdata (w_q)
    );

    // Read source is chosen at accept time; it holds while rd_en is low
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_valid <= 1'b0;
            r_sel      <= RD_BYPASS;
            r_byp_data <= '0;
        end else begin
            r_rd_valid <= w_rd_acc;
            if (w_rd_acc) begin
                if (!w_rd_in) begin
                    r_sel <= RD_CLEAR;
                end else if (w_byp) begin
                    r_sel      <= RD_BYPASS;
                    r_byp_data <= bus.wr_data;
                end else begin
                    r_sel <= RD_ARRAY;
                end
            end
        end
    end

    always_comb begin
        case (r_sel)
            RD_ARRAY: bus.rd_data = w_q[DATA_W-1:0];
            RD_CLEAR: bus.rd_data = CLEAR_VAL;
            default:  bus.rd_data = r_byp_data;
        endcase
    end

    assign bus.rd_valid  = r_rd_valid;
    assign bus.init_busy = ~w_ready;

`ifdef PARAM_SDP_MEM_PARITY_EN
    assign bus.parity_err = r_rd_valid & (r_sel == RD_ARRAY)
                          & (w_q[DATA_W] != even_parity(64'(w_q[DATA_W-1:0])));
`else
    assign bus.parity_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_param_sdp_mem.sv
// ============================================================================
// Module   : tb_param_sdp_mem
// Brief    : Scoreboard bench for param_sdp_mem (DEPTH=256 and DEPTH=200 units).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_param_sdp_mem;

    logic clk = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;

    always #5 clk = ~clk;

    param_sdp_mem_if #(.DATA_W(16), .ADDR_W(8)) ifa();
    param_sdp_mem_if #(.DATA_W(16), .ADDR_W(8)) ifb();

    param_sdp_mem #(.DATA_W(16), .ADDR_W(8), .DEPTH(256), .CLEAR_VAL(16'h0000))
        u_a (.clk(clk), .rst(rst_a), .bus(ifa.slave));

    param_sdp_mem #(.DATA_W(16), .ADDR_W(8), .DEPTH(200), .CLEAR_VAL(16'h0000))
        u_b (.clk(clk), .rst(rst_b), .bus(ifb.slave));

    typedef struct packed {
        logic [15:0] data;
        logic        perr;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t e_a, e_b;
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitors: pop one expected entry per presented rd_valid
    always @(negedge clk) begin
        if (ifa.rd_valid) begin
            if (qa.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL a_unexpected_valid: got rd_valid=1 data %h, expected no read", ifa.rd_data);
            end else begin
                e_a = qa.pop_front();
                check("a_rd_data", 32'(ifa.rd_data), 32'(e_a.data));
                check("a_parity_err", 32'(ifa.parity_err), 32'(e_a.perr));
            end
        end else if (ifa.parity_err) begin
            check("a_parity_idle", 32'(ifa.parity_err), 32'd0);
        end
    end

    always @(negedge clk) begin
        if (ifb.rd_valid) begin
            if (qb.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL b_unexpected_valid: got rd_valid=1 data %h, expected no read", ifb.rd_data);
            end else begin
                e_b = qb.pop_front();
                check("b_rd_data", 32'(ifb.rd_data), 32'(e_b.data));
                check("b_parity_err", 32'(ifb.parity_err), 32'(e_b.perr));
            end
        end
    end

    task automatic drv_a(input logic we, input logic [7:0] wa, input logic [15:0] wd,
                         input logic re, input logic [7:0] ra);
        ifa.wr_en = we; ifa.wr_addr = wa; ifa.wr_data = wd;
        ifa.rd_en = re; ifa.rd_addr = ra;
        @(negedge clk);
        ifa.wr_en = 1'b0; ifa.rd_en = 1'b0;
    endtask

    task automatic drv_b(input logic we, input logic [7:0] wa, input logic [15:0] wd,
                         input logic re, input logic [7:0] ra);
        ifb.wr_en = we; ifb.wr_addr = wa; ifb.wr_data = wd;
        ifb.rd_en = re; ifb.rd_addr = ra;
        @(negedge clk);
        ifb.wr_en = 1'b0; ifb.rd_en = 1'b0;
    endtask

    task automatic rd_a(input logic [7:0] ra, input logic [15:0] d, input logic p);
        qa.push_back('{data: d, perr: p});
        drv_a(1'b0, 8'h00, 16'h0000, 1'b1, ra);
    endtask

    task automatic rd_b(input logic [7:0] ra, input logic [15:0] d);
        qb.push_back('{data: d, perr: 1'b0});
        drv_b(1'b0, 8'h00, 16'h0000, 1'b1, ra);
    endtask

    initial begin
        #200us;
        $display("FAIL timeout: simulation did not complete, expected finish before 200us");
        $fatal(1, "timeout");
    end

    initial begin
        ifa.wr_en = 1'b0; ifa.wr_addr = '0; ifa.wr_data = '0; ifa.rd_en = 1'b0; ifa.rd_addr = '0;
        ifb.wr_en = 1'b0; ifb.wr_addr = '0; ifb.wr_data = '0; ifb.rd_en = 1'b0; ifb.rd_addr = '0;

        repeat (3) @(negedge clk);
        check("reset_busy", 32'(ifa.init_busy), 32'd1);
        check("reset_rd_valid", 32'(ifa.rd_valid), 32'd0);
        check("reset_rd_data", 32'(ifa.rd_data), 32'd0);
        check("reset_parity_err", 32'(ifa.parity_err), 32'd0);

        // Current negedge lies in cycle 0 once rst is dropped here
        rst_a = 1'b0;
        rst_b = 1'b0;
        for (int c = 0; c <= 256; c++) begin
            if (c == 0 || c == 255 || c == 256)
                check($sformatf("a_busy_c%0d", c), 32'(ifa.init_busy), 32'(c < 256));
            if (c == 199 || c == 200)
                check($sformatf("b_busy_c%0d", c), 32'(ifb.init_busy), 32'(c < 200));
            if (c < 256) @(negedge clk);
        end

        rd_a(8'h00, 16'h0000, 1'b0);
        rd_a(8'hFF, 16'h0000, 1'b0);

        drv_a(1'b1, 8'h10, 16'hA5A5, 1'b0, 8'h00);
        rd_a(8'h10, 16'hA5A5, 1'b0);

        // Write-first: simultaneous write and read of 0x20
        qa.push_back('{data: 16'h1234, perr: 1'b0});
        drv_a(1'b1, 8'h20, 16'h1234, 1'b1, 8'h20);
        rd_a(8'h20, 16'h1234, 1'b0);
        @(negedge clk);
        check("a_hold_valid", 32'(ifa.rd_valid), 32'd0);
        check("a_hold_data", 32'(ifa.rd_data), 32'h1234);

        // Simultaneous write and read of different addresses
        qa.push_back('{data: 16'hA5A5, perr: 1'b0});
        drv_a(1'b1, 8'h21, 16'h5555, 1'b1, 8'h10);
        rd_a(8'h21, 16'h5555, 1'b0);

        // Out-of-range handling on the DEPTH=200 unit
        drv_b(1'b1, 8'hC8, 16'h7777, 1'b0, 8'h00);
        rd_b(8'hC8, 16'h0000);
        rd_b(8'hC7, 16'h0000);
        drv_b(1'b1, 8'hC7, 16'h1111, 1'b0, 8'h00);
        rd_b(8'hC7, 16'h1111);
        rd_b(8'hFF, 16'h0000);

`ifdef PARAM_SDP_MEM_PARITY_EN
        drv_a(1'b1, 8'h30, 16'h00FF, 1'b0, 8'h00);
        u_a.u_array.r_mem[8'h30][0] = ~u_a.u_array.r_mem[8'h30][0];
        rd_a(8'h30, 16'h00FE, 1'b1);
        rd_a(8'h10, 16'hA5A5, 1'b0);
`endif

        // Reset from READY, then reset again at cycle 100 of the clear
        rst_a = 1'b1;
        @(negedge clk);
        rst_a = 1'b0;
        repeat (50) @(negedge clk);
        drv_a(1'b1, 8'h05, 16'hBEEF, 1'b1, 8'h05);
        repeat (49) @(negedge clk);
        rst_a = 1'b1;
        @(negedge clk);
        rst_a = 1'b0;
        for (int c = 0; c <= 256; c++) begin
            if (c == 0 || c == 255 || c == 256)
                check($sformatf("a_reclear_busy_c%0d", c), 32'(ifa.init_busy), 32'(c < 256));
            if (c == 250) begin
                // Pointer is past 0x05 here, so a leaked write would survive
                drv_a(1'b1, 8'h05, 16'hBEEF, 1'b1, 8'h05);
            end else if (c < 256) begin
                @(negedge clk);
            end
        end

        rd_a(8'h05, 16'h0000, 1'b0);
        rd_a(8'h10, 16'h0000, 1'b0);
        rd_a(8'h20, 16'h0000, 1'b0);

        repeat (3) @(negedge clk);
        check("a_queue_empty", 32'(qa.size()), 32'd0);
        check("b_queue_empty", 32'(qb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
